// File: rtl/demux1_4_buffered.sv
// ============================================================================
// Module  : demux1_4_buffered
// Purpose : 1-to-4 demultiplexer with a one-entry valid/ready buffer per channel
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module demux1_4_buffered #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       sel,
    input  logic [WIDTH-1:0] D,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [WIDTH-1:0] Y0,
    output logic [WIDTH-1:0] Y1,
    output logic [WIDTH-1:0] Y2,
    output logic [WIDTH-1:0] Y3,
    output logic             busy
);

    localparam int c_NUM_CH = 4;

    logic [c_NUM_CH-1:0] w_valid;
    logic [WIDTH-1:0]    w_y [c_NUM_CH];
    logic                w_in_xfer;

    // Ready looks only at the addressed channel so a stalled neighbour never blocks.
    assign in_ready  = !w_valid[sel] || out_ready[sel];
    assign w_in_xfer = in_valid && in_ready;

    generate
        for (genvar i = 0; i < c_NUM_CH; i++) begin : g_ch
            logic             valid_q;
            logic             valid_d;
            logic [WIDTH-1:0] y_q;
            logic [WIDTH-1:0] y_d;
            logic             w_load;
            logic             w_out_xfer;

            assign w_load     = w_in_xfer && (sel == i[1:0]);
            assign w_out_xfer = valid_q && out_ready[i];

            // A load in the same cycle as a drain keeps the flag set: no bubble.
            always_comb begin
                valid_d = valid_q;
                y_d     = y_q;
                if (w_load) begin
                    valid_d = 1'b1;
                    y_d     = D;
                end else if (w_out_xfer) begin
                    valid_d = 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    valid_q <= 1'b0;
                    y_q     <= '0;
                end else begin
                    valid_q <= valid_d;
                    y_q     <= y_d;
                end
            end

            assign w_valid[i] = valid_q;
            assign w_y[i]     = y_q;
        end
    endgenerate

    assign out_valid = w_valid;
    assign busy      = |w_valid;
    assign Y0        = w_y[0];
    assign Y1        = w_y[1];
    assign Y2        = w_y[2];
    assign Y3        = w_y[3];

endmodule

`default_nettype wire

// File: tb/tb_demux1_4_buffered.sv
// ============================================================================
// Module  : tb_demux1_4_buffered
// Purpose : directed checks plus a queue-scoreboard random phase for the demux
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_demux1_4_buffered;

    localparam int WIDTH = 32;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       sel;
    logic [WIDTH-1:0] D;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic [WIDTH-1:0] Y0, Y1, Y2, Y3;
    logic             busy;
    logic [WIDTH-1:0] y_arr [4];

    int n_checks;
    int n_fails;

    logic [WIDTH-1:0] sbq [4][$];

    demux1_4_buffered #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sel      (sel),
        .D        (D),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Y0       (Y0),
        .Y1       (Y1),
        .Y2       (Y2),
        .Y3       (Y3),
        .busy     (busy)
    );

    assign y_arr[0] = Y0;
    assign y_arr[1] = Y1;
    assign y_arr[2] = Y2;
    assign y_arr[3] = Y3;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; checks happen on the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_clear(input string tag);
        chk({tag, "_ov"}, {28'd0, out_valid}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        for (int i = 0; i < 4; i++) chk({tag, "_y"}, y_arr[i], 32'd0);
    endtask

    // One scoreboard cycle: drive, compare on the falling edge, update the model.
    task automatic sb_cycle(input logic v, input logic [1:0] s, input logic [WIDTH-1:0] d,
                            input logic [3:0] ordy);
        logic       exp_rdy;
        logic [3:0] exp_ov;
        in_valid  = v;
        sel       = s;
        D         = d;
        out_ready = ordy;
        @(negedge clk);
        for (int i = 0; i < 4; i++) exp_ov[i] = (sbq[i].size() != 0);
        exp_rdy = !exp_ov[s] || ordy[s];
        chk("sb_in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
        chk("sb_out_valid", {28'd0, out_valid}, {28'd0, exp_ov});
        for (int i = 0; i < 4; i++) begin
            if (exp_ov[i]) begin
                chk("sb_y_front", y_arr[i], sbq[i][0]);
                if (ordy[i]) void'(sbq[i].pop_front());
            end
        end
        if (v && exp_rdy) sbq[s].push_back(d);
        tick();
    endtask

    initial begin
        n_checks  = 0;
        n_fails   = 0;
        reset     = 1'b1;
        in_valid  = 1'b0;
        sel       = 2'd0;
        D         = '0;
        out_ready = 4'b0000;
        tick();
        tick();
        reset = 1'b0;

        // Reset state and ready in the first cycle after release.
        @(negedge clk);
        chk_all_clear("reset");
        chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Single word into channel 2.
        tick();
        in_valid = 1'b1; sel = 2'd2; D = 32'hDEADBEEF;
        @(negedge clk);
        chk("ch2_load_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ch2_ov", {28'd0, out_valid}, 32'h4);
        chk("ch2_y2", Y2, 32'hDEADBEEF);
        chk("ch2_y0", Y0, 32'd0);
        chk("ch2_y1", Y1, 32'd0);
        chk("ch2_y3", Y3, 32'd0);
        chk("ch2_busy", {31'd0, busy}, 32'd1);

        // Stalled channel 2 refuses, channel 1 still accepts.
        tick();
        in_valid = 1'b1; sel = 2'd2; D = 32'h1;
        @(negedge clk);
        chk("stall_ready", {31'd0, in_ready}, 32'd0);
        tick();
        sel = 2'd1;
        @(negedge clk);
        chk("stall_y2_hold", Y2, 32'hDEADBEEF);
        chk("stall_ov_hold", {28'd0, out_valid}, 32'h4);
        chk("ch1_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ch1_ov", {28'd0, out_valid}, 32'h6);
        chk("ch1_y1", Y1, 32'h1);
        chk("ch1_y2_hold", Y2, 32'hDEADBEEF);

        // out_ready on empty channels has no effect.
        tick();
        out_ready = 4'b1001;
        tick();
        out_ready = 4'b0000;
        @(negedge clk);
        chk("idle_ready_ov", {28'd0, out_valid}, 32'h6);

        // Channel 0: simultaneous drain and refill.
        tick();
        in_valid = 1'b1; sel = 2'd0; D = 32'hA;
        tick();
        out_ready = 4'b0001; D = 32'hB;
        @(negedge clk);
        chk("ch0_pre_y0", Y0, 32'hA);
        chk("ch0_pass_ready", {31'd0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0; out_ready = 4'b0000;
        @(negedge clk);
        chk("ch0_pass_ov", {28'd0, out_valid}, 32'h7);
        chk("ch0_pass_y0", Y0, 32'hB);

        // Drain without refill: flag clears, data holds.
        tick();
        out_ready = 4'b0001;
        tick();
        out_ready = 4'b0000;
        @(negedge clk);
        chk("ch0_drain_ov", {28'd0, out_valid}, 32'h6);
        chk("ch0_drain_y0", Y0, 32'hB);
        tick();
        out_ready = 4'b0110;
        tick();
        out_ready = 4'b0000;
        @(negedge clk);
        chk("drain_all_ov", {28'd0, out_valid}, 32'h0);
        chk("drain_all_busy", {31'd0, busy}, 32'd0);

        // Full-throughput stream on channel 3.
        tick();
        out_ready = 4'b1000;
        for (int k = 1; k <= 4; k++) begin
            in_valid = 1'b1; sel = 2'd3; D = k;
            @(negedge clk);
            chk("stream_ready", {31'd0, in_ready}, 32'd1);
            if (k > 1) begin
                chk("stream_ov3", {31'd0, out_valid[3]}, 32'd1);
                chk("stream_y3", Y3, k - 1);
            end
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("stream_last_y3", Y3, 32'd4);
        chk("stream_last_ov3", {31'd0, out_valid[3]}, 32'd1);
        tick();
        out_ready = 4'b0000;
        @(negedge clk);
        chk("stream_end_ov3", {31'd0, out_valid[3]}, 32'd0);

        // All channels full, then reset while a transfer is offered.
        tick();
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; sel = i[1:0]; D = 32'h10 + i;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("full_ov", {28'd0, out_valid}, 32'hF);
        chk("full_y3", Y3, 32'h13);
        tick();
        reset = 1'b1; in_valid = 1'b1; sel = 2'd1; D = 32'hCAFEF00D; out_ready = 4'b1111;
        tick();
        reset = 1'b0; in_valid = 1'b0; out_ready = 4'b0000;
        @(negedge clk);
        chk_all_clear("reset_mid");

        // in_valid low: sel and D are ignored.
        tick();
        sel = 2'd2; D = 32'h55AA55AA;
        tick();
        @(negedge clk);
        chk_all_clear("idle_inputs");

        // Random traffic against per-channel queues.
        tick();
        for (int c = 0; c < 400; c++) begin
            sb_cycle($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom,
                     4'($urandom_range(0, 15)));
        end
        for (int c = 0; c < 3; c++) sb_cycle(1'b0, 2'd0, '0, 4'b1111);
        for (int i = 0; i < 4; i++) chk("sb_drained", sbq[i].size(), 32'd0);
        @(negedge clk);
        chk("sb_final_ov", {28'd0, out_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
